// File: rtl/afifo_buf2.sv
// Two-entry circular register buffer: push at tail, pop at head, head word and
// occupancy count exposed directly from registers.
module afifo_buf2 #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] wdata,
  input  logic             pop,
  output logic [DSIZE-1:0] head_data,
  output logic [1:0]       count
);

  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [DSIZE-1:0] ent0_q, ent0_d;
  logic [DSIZE-1:0] ent1_q, ent1_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      if (tail_q) ent1_d = wdata;
      else        ent0_d = wdata;
      tail_d = ~tail_q;
    end
    if (pop) head_d = ~head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  // No bypass: a word pushed this cycle becomes visible only from the next cycle.
  assign head_data = head_q ? ent1_q : ent0_q;
  assign count     = count_q;

endmodule

// File: rtl/afifo_rd_fwft.sv
// Read-side FWFT output stage of the async FIFO: issues ren against a 2-credit
// budget, captures one-cycle-latency RAM data and presents a valid/ready stream.
module afifo_rd_fwft #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             empty,
  output logic             ren,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       level
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic       pop;
  logic [2:0] free;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // occ + inflight never exceeds 2, so this cannot underflow. Counting the
  // current pop as a credit is what lets ren stay high every cycle while
  // m_ready holds; the m_ready -> ren combinational path is deliberate.
  always_comb begin
    free       = 3'd2 - {1'b0, occ} - {2'b00, inflight_q} + {2'b00, pop};
    ren        = ~empty & (free != 3'd0);
    inflight_d = ren;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  afifo_buf2 #(.DSIZE(DSIZE)) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (inflight_q),
    .wdata     (rdata),
    .pop       (pop),
    .head_data (m_data),
    .count     (occ)
  );

  assign level = occ;

endmodule

// File: tb/tb_afifo_rd_fwft.sv
// Bench for afifo_rd_fwft: table of per-cycle vectors for the single-word case,
// then a FIFO/RAM model with an in-order scoreboard for streaming sequences.
module tb_afifo_rd_fwft;
  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       empty;
  logic       ren;
  logic [7:0] rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;

  always #5 rclk = ~rclk;

  afifo_rd_fwft #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .empty   (empty),
    .ren     (ren),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic       emp;
    logic       rdy;
    logic [7:0] rd;
    logic       e_ren;
    logic       e_vld;
    logic [7:0] e_data;
    logic [1:0] e_lvl;
  } vec_t;
  vec_t vt[9];

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       pend_v;
  logic [7:0] pend_d;
  int         cyc;
  int         npop;
  int         ren_cyc[$];
  int         pop_cyc[$];

  // One read-domain cycle: drive on negedge, sample 1ns later, update the model at posedge.
  task automatic step(input logic rdy, input logic force_emp);
    logic       s_ren, s_vld, s_emp;
    logic [7:0] s_data;
    @(negedge rclk);
    rdata   = pend_v ? pend_d : 8'hEE;
    empty   = force_emp || (src_q.size() == 0);
    m_ready = rdy;
    #1;
    s_ren  = ren;
    s_vld  = m_valid;
    s_emp  = empty;
    s_data = m_data;
    chk("ren_while_empty", {31'd0, s_ren & s_emp}, 32'd0);
    chk("level_le_2", {31'd0, level == 2'd3}, 32'd0);
    @(posedge rclk);
    cyc++;
    pend_v = 1'b0;
    if (s_ren && !s_emp && src_q.size() != 0) begin
      pend_d = src_q.pop_front();
      pend_v = 1'b1;
      exp_q.push_back(pend_d);
      ren_cyc.push_back(cyc);
    end
    if (s_vld && rdy) begin
      npop++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else chk("pop_data", {24'd0, s_data}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    int base;
    vt[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0};
    vt[1] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 2'd0};
    for (int i = 2; i <= 6; i++) vt[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 2'd1};
    vt[7] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 2'd1};
    vt[8] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0};

    pend_v = 1'b0; pend_d = 8'h00; cyc = 0; npop = 0;

    // Reset state
    rrst_n = 1'b0; empty = 1'b1; m_ready = 1'b0; rdata = 8'h00;
    #12;
    chk("rst_ren", {31'd0, ren}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Single word 0xA5 with stalls
    for (int i = 0; i < 9; i++) begin
      @(negedge rclk);
      empty = vt[i].emp; m_ready = vt[i].rdy; rdata = vt[i].rd;
      #1;
      chk($sformatf("vec%0d_ren", i), {31'd0, ren}, {31'd0, vt[i].e_ren});
      chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vt[i].e_vld});
      chk($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vt[i].e_data});
      chk($sformatf("vec%0d_level", i), {30'd0, level}, {30'd0, vt[i].e_lvl});
    end

    // Stream 0x00..0x0F with m_ready held high
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    ren_cyc.delete(); pop_cyc.delete(); base = npop;
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
    chk("stream_ren_cnt", ren_cyc.size(), 32'd16);
    chk("stream_pop_cnt", pop_cyc.size(), 32'd16);
    if (ren_cyc.size() == 16 && pop_cyc.size() == 16) begin
      chk("stream_ren_consec", ren_cyc[15] - ren_cyc[0], 32'd15);
      chk("stream_first_lat", pop_cyc[0] - ren_cyc[0], 32'd2);
      chk("stream_pop_consec", pop_cyc[15] - pop_cyc[0], 32'd15);
    end
    chk("stream_drained", exp_q.size(), 32'd0);

    // Backpressure with 8 words waiting
    for (int i = 0; i < 8; i++) src_q.push_back(8'h80 + 8'(i));
    ren_cyc.delete(); base = npop;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    chk("bp_ren_pulses", ren_cyc.size(), 32'd2);
    @(negedge rclk);
    #1;
    chk("bp_level_full", {30'd0, level}, 32'd2);
    chk("bp_ren_off", {31'd0, ren}, 32'd0);
    chk("bp_m_data_head", {24'd0, m_data}, 32'h80);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
    chk("bp_pop_cnt", npop - base, 32'd8);
    chk("bp_drained", exp_q.size() + src_q.size(), 32'd0);

    // Random ready/empty with 256 words
    for (int i = 0; i < 256; i++) src_q.push_back(8'($urandom_range(0, 255)));
    base = npop;
    for (int i = 0; i < 4000 && (npop - base) < 256; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    chk("rand_pop_cnt", npop - base, 32'd256);
    chk("rand_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-stream with a word buffered and one in flight
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge rclk);
    #2;
    chk("pre_rst_level", {30'd0, level}, 32'd1);
    rrst_n = 1'b0; empty = 1'b1;
    #1;
    chk("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("async_rst_level", {30'd0, level}, 32'd0);
    chk("async_rst_m_data", {24'd0, m_data}, 32'd0);
    chk("async_rst_ren", {31'd0, ren}, 32'd0);
    src_q.delete(); exp_q.delete(); pend_v = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    ren_cyc.delete(); base = npop;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("post_rst_no_ren", ren_cyc.size(), 32'd0);
    src_q.push_back(8'h5C); src_q.push_back(8'h6D);
    pop_cyc.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("post_rst_pop_cnt", npop - base, 32'd2);
    chk("post_rst_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
